// File: rtl/conv1d_window_feeder_pkg.sv
// Shared types and constants for the 3-tap 1-D convolution window feeder.
// The tap count is fixed by the 3-PE array this block feeds.
package conv1d_window_feeder_pkg;

  localparam int TAPS               = 3;
  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_LEN_WIDTH  = 16;
  localparam int DEFAULT_PSUM_WIDTH = 16;

  typedef logic [1:0] tap_idx_t;
  localparam tap_idx_t LAST_TAP = tap_idx_t'(TAPS - 1);

  // Terminal drain count: the lane-2 skew line has emptied by this cycle.
  localparam logic [1:0] DRAIN_LAST = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_FILL,
    S_RUN,
    S_DRAIN
  } state_t;

endpackage

// File: rtl/conv1d_window_feeder_skew_delay.sv
// N-stage data+valid delay line; the output reads zero whenever the
// delayed valid is low, so idle lanes never show stale samples.
module skew_delay
  import conv1d_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int STAGES     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] data_q [STAGES];
  logic [STAGES-1:0]     valid_q;

  // Shifts every clock regardless of upstream handshake to keep lanes aligned.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
      valid_q <= '0;
    end else begin
      data_q[0]  <= in_data;
      valid_q[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) begin
        data_q[i]  <= data_q[i-1];
        valid_q[i] <= valid_q[i-1];
      end
    end
  end

  assign out_data = valid_q[STAGES-1] ? data_q[STAGES-1] : '0;

endmodule

// File: rtl/conv1d_window_feeder.sv
// Loads 3 kernel weights, then turns a valid/ready sample stream into
// overlapping 3-tap windows, skewed one cycle per lane for the PE chain.
module conv1d_window_feeder
  import conv1d_window_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int LEN_WIDTH  = DEFAULT_LEN_WIDTH,
  parameter int PSUM_WIDTH = DEFAULT_PSUM_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  sig_len,
  input  logic                  w_valid,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  s_valid,
  input  logic [DATA_WIDTH-1:0] s_data,
  output logic                  s_ready,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic [DATA_WIDTH-1:0] data_out2,
  output logic [DATA_WIDTH-1:0] weight_out0,
  output logic [DATA_WIDTH-1:0] weight_out1,
  output logic [DATA_WIDTH-1:0] weight_out2,
  output logic [PSUM_WIDTH-1:0] psum_seed,
  output logic                  valid_out,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err
);

  state_t state, state_next;

  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  win_cnt;
  tap_idx_t              w_idx;
  logic                  fill_cnt;
  logic [1:0]            drain_cnt;
  logic [DATA_WIDTH-1:0] w_q    [TAPS];
  logic [DATA_WIDTH-1:0] x_m2, x_m1;
  logic [DATA_WIDTH-1:0] lane_d [TAPS];
  logic                  lane_v;

  logic accept;
  logic start_ok, start_bad;
  logic w_take, run_accept, finish;

  assign s_ready = (state == S_FILL) || (state == S_RUN);
  assign accept  = s_valid && s_ready;
  assign busy    = (state != S_IDLE);

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    w_take     = 1'b0;
    run_accept = 1'b0;
    finish     = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (sig_len >= LEN_WIDTH'(TAPS)) begin
            start_ok   = 1'b1;
            state_next = S_LOAD_W;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_LOAD_W: begin
        if (w_valid) begin
          w_take = 1'b1;
          if (w_idx == LAST_TAP) state_next = S_FILL;
        end
      end
      S_FILL: begin
        if (accept && fill_cnt) state_next = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          run_accept = 1'b1;
          // win_cnt counts windows already issued; this one is the last of sig_len-2.
          if (win_cnt == len_q - LEN_WIDTH'(TAPS)) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          finish     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      len_q     <= '0;
      win_cnt   <= '0;
      w_idx     <= '0;
      fill_cnt  <= 1'b0;
      drain_cnt <= '0;
      x_m2      <= '0;
      x_m1      <= '0;
      lane_v    <= 1'b0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      for (int i = 0; i < TAPS; i++) begin
        w_q[i]    <= '0;
        lane_d[i] <= '0;
      end
    end else begin
      done    <= finish;
      len_err <= start_bad;

      if (start_ok) begin
        len_q    <= sig_len;
        win_cnt  <= '0;
        w_idx    <= '0;
        fill_cnt <= 1'b0;
      end

      if (w_take) begin
        w_q[w_idx] <= w_data;
        w_idx      <= w_idx + 1'b1;
      end

      if (accept) begin
        x_m2 <= x_m1;
        x_m1 <= s_data;
      end
      if (state == S_FILL && accept) fill_cnt <= 1'b1;
      if (run_accept) win_cnt <= win_cnt + 1'b1;

      // Lane-0 stage; lanes 1 and 2 take their extra skew from the delay lines.
      lane_v    <= run_accept;
      lane_d[0] <= run_accept ? x_m2   : '0;
      lane_d[1] <= run_accept ? x_m1   : '0;
      lane_d[2] <= run_accept ? s_data : '0;

      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;
    end
  end

  skew_delay #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (1)
  ) u_lane1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (lane_d[1]),
    .in_valid (lane_v),
    .out_data (data_out1)
  );

  skew_delay #(
    .DATA_WIDTH (DATA_WIDTH),
    .STAGES     (2)
  ) u_lane2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (lane_d[2]),
    .in_valid (lane_v),
    .out_data (data_out2)
  );

  assign data_out0   = lane_d[0];
  assign valid_out   = lane_v;
  assign weight_out0 = w_q[0];
  assign weight_out1 = w_q[1];
  assign weight_out2 = w_q[2];
  assign psum_seed   = '0;

endmodule

// File: tb/tb_conv1d_window_feeder.sv
// Directed bench for conv1d_window_feeder: 5-sample frames (10..50) with
// and without backpressure, weight stalls, length error, resets and ignored start.
module tb_conv1d_window_feeder;

  localparam int DW   = 8;
  localparam int LW   = 16;
  localparam int PW   = 16;
  localparam int LOGN = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [LW-1:0] sig_len;
  logic          w_valid;
  logic [DW-1:0] w_data;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [DW-1:0] data_out0, data_out1, data_out2;
  logic [DW-1:0] weight_out0, weight_out1, weight_out2;
  logic [PW-1:0] psum_seed;
  logic          valid_out, busy, done, len_err;

  int vectors     = 0;
  int miscompares = 0;

  logic          lv    [LOGN];
  logic [DW-1:0] l0    [LOGN];
  logic [DW-1:0] l1    [LOGN];
  logic [DW-1:0] l2    [LOGN];
  logic          ldone [LOGN];

  conv1d_window_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .sig_len     (sig_len),
    .w_valid     (w_valid),
    .w_data      (w_data),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .data_out0   (data_out0),
    .data_out1   (data_out1),
    .data_out2   (data_out2),
    .weight_out0 (weight_out0),
    .weight_out1 (weight_out1),
    .weight_out2 (weight_out2),
    .psum_seed   (psum_seed),
    .valid_out   (valid_out),
    .busy        (busy),
    .done        (done),
    .len_err     (len_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Outputs are observed 1 ns after the rising edge, inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_weights(input string tag, input int a, input int b, input int c);
    check({tag, " w0"}, 32'(weight_out0), 32'(a));
    check({tag, " w1"}, 32'(weight_out1), 32'(b));
    check({tag, " w2"}, 32'(weight_out2), 32'(c));
  endtask

  task automatic start_frame(input int len);
    start   = 1'b1;
    sig_len = LW'(len);
    tick();
    start = 1'b0;
    check("start busy", 32'(busy), 32'd1);
    check("start s_ready in LOAD_W", 32'(s_ready), 32'd0);
  endtask

  task automatic load_weights(input int a, input int b, input int c, input int gap);
    int vals [3];
    vals = '{a, b, c};
    for (int i = 0; i < 3; i++) begin
      w_valid = 1'b1;
      w_data  = DW'(vals[i]);
      tick();
      w_valid = 1'b0;
      w_data  = 8'hA5;
      if (i < 2) begin
        check($sformatf("load beat%0d s_ready", i), 32'(s_ready), 32'd0);
        for (int g = 0; g < gap; g++) begin
          tick();
          check($sformatf("stall beat%0d gap%0d s_ready", i, g), 32'(s_ready), 32'd0);
          check($sformatf("stall beat%0d gap%0d busy", i, g), 32'(busy), 32'd1);
        end
      end
    end
    check("FILL s_ready", 32'(s_ready), 32'd1);
  endtask

  // Streams samples 10,20,30,40,50 with 'gap' idle cycles after each accepted
  // beat, logging outputs for LOGN cycles. Optionally pulses start mid-RUN and
  // holds junk on the weight port throughout.
  task automatic stream(input int gap, input bit pulse_start);
    int idx, wait_c;
    bit acc, pulsed;
    idx = 0; wait_c = 0; pulsed = 1'b0;
    for (int c = 0; c < LOGN; c++) begin
      s_valid = (idx < 5) && (wait_c == 0);
      s_data  = s_valid ? DW'(10 * (idx + 1)) : 8'hEE;
      start   = pulse_start && !pulsed && idx == 3;
      if (start) pulsed = 1'b1;
      w_valid = pulse_start;
      w_data  = 8'h77;
      acc = s_valid && s_ready;
      tick();
      lv[c] = valid_out; l0[c] = data_out0; l1[c] = data_out1; l2[c] = data_out2;
      ldone[c] = done;
      if (acc) begin
        idx++;
        wait_c = gap;
      end else if (wait_c > 0) begin
        wait_c--;
      end
    end
    s_valid = 1'b0; start = 1'b0; w_valid = 1'b0;
  endtask

  // Windows (10,20,30),(20,30,40),(30,40,50) issued every p=gap+1 cycles from
  // first valid t: lane0 at t+j*p, lane1 one later, lane2 two later; done 3
  // cycles after the last lane-0 issue.
  task automatic check_trace(input string name, input int gap);
    int t, p, dones, ev, e0, e1, e2, ed;
    t = -1; p = gap + 1; dones = 0;
    for (int c = 0; c < LOGN; c++) begin
      if (t < 0 && lv[c]) t = c;
      if (ldone[c]) dones++;
    end
    check({name, " first valid seen"}, 32'(t >= 0), 32'd1);
    check({name, " single done"}, 32'(dones), 32'd1);
    if (t >= 0) begin
      for (int k = 0; k <= 2 * p + 4; k++) begin
        if (t + k < LOGN) begin
          ev = (k % p == 0 && k / p < 3) ? 1 : 0;
          e0 = ev ? 10 * (k / p + 1) : 0;
          e1 = (k >= 1 && (k - 1) % p == 0 && (k - 1) / p < 3) ? 10 * ((k - 1) / p + 2) : 0;
          e2 = (k >= 2 && (k - 2) % p == 0 && (k - 2) / p < 3) ? 10 * ((k - 2) / p + 3) : 0;
          ed = (k == 2 * p + 3) ? 1 : 0;
          check($sformatf("%s t+%0d valid_out", name, k), 32'(lv[t+k]), 32'(ev));
          check($sformatf("%s t+%0d data_out0", name, k), 32'(l0[t+k]), 32'(e0));
          check($sformatf("%s t+%0d data_out1", name, k), 32'(l1[t+k]), 32'(e1));
          check($sformatf("%s t+%0d data_out2", name, k), 32'(l2[t+k]), 32'(e2));
          check($sformatf("%s t+%0d done", name, k), 32'(ldone[t+k]), 32'(ed));
        end
      end
    end
    check({name, " idle after frame"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int seen_done;
    rst_n = 1'b0; start = 1'b0; sig_len = '0;
    w_valid = 1'b0; w_data = '0; s_valid = 1'b0; s_data = '0;
    tick(); tick();
    rst_n = 1'b1;

    check("reset valid_out", 32'(valid_out), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset s_ready", 32'(s_ready), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset len_err", 32'(len_err), 32'd0);
    check("reset lanes", {8'd0, data_out0, data_out1, data_out2}, 32'd0);
    check("psum_seed", 32'(psum_seed), 32'd0);
    check_weights("reset", 0, 0, 0);

    // Too-short frame is rejected with a single len_err pulse.
    start = 1'b1; sig_len = 16'd2;
    tick();
    start = 1'b0;
    check("len_err pulse", 32'(len_err), 32'd1);
    check("len_err busy", 32'(busy), 32'd0);
    check("len_err s_ready", 32'(s_ready), 32'd0);
    tick();
    check("len_err cleared", 32'(len_err), 32'd0);
    check("len_err still idle", 32'(busy), 32'd0);

    // Basic frame.
    start_frame(5);
    load_weights(1, 2, 3, 0);
    stream(0, 1'b0);
    check_trace("basic", 0);
    check_weights("basic held", 1, 2, 3);

    // Backpressure with stalled weight loading.
    start_frame(5);
    load_weights(4, 5, 6, 3);
    stream(2, 1'b0);
    check_trace("backpressure", 2);
    check_weights("stall held", 4, 5, 6);

    // start pulsed in RUN and junk weight beats are both ignored.
    start_frame(5);
    load_weights(1, 2, 3, 0);
    stream(0, 1'b1);
    check_trace("start_in_run", 0);
    check_weights("junk ignored", 1, 2, 3);

    // Reset after the first window.
    start_frame(5);
    load_weights(7, 8, 9, 0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(10 * (i + 1));
      tick();
    end
    s_valid = 1'b0;
    check("pre-reset valid_out", 32'(valid_out), 32'd1);
    check("pre-reset data_out0", 32'(data_out0), 32'd10);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid-reset valid_out", 32'(valid_out), 32'd0);
    check("mid-reset lanes", {8'd0, data_out0, data_out1, data_out2}, 32'd0);
    check("mid-reset busy", 32'(busy), 32'd0);
    check("mid-reset s_ready", 32'(s_ready), 32'd0);
    check_weights("mid-reset", 0, 0, 0);
    seen_done = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (done) seen_done++;
    end
    check("no done after abort", 32'(seen_done), 32'd0);

    start_frame(5);
    load_weights(1, 2, 3, 0);
    stream(0, 1'b0);
    check_trace("after_reset", 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
